// File: rtl/status_display_scan.sv
// Scans the packed FSM status, floor code and timer onto a 4-digit multiplexed seven-segment display.
// Latency: inputs pass 2 sync flops and land in the shadow at the next frame wrap; pins update 1 cycle after index/shadow change.
// Backpressure: none; the scan free-runs, and a status held for less than a frame can be missed.
module status_display_scan #(
    parameter int REFRESH_CNT  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] status_in,
    input  logic [1:0] level_in,
    input  logic [3:0] clock_in,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int RW = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
    localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CNT - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    SEG_BLANK    = 7'h7F;
    localparam logic [6:0]    SEG_E        = 7'h06;
    localparam logic [6:0]    SEG_U        = 7'h41;
    localparam logic [6:0]    SEG_D        = 7'h21;

    logic [7:0]    status_s1, status_s2, status_sh;
    logic [1:0]    level_s1, level_s2, level_sh;
    logic [3:0]    clock_s1, clock_s2, clock_sh;
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    scan_idx;
    logic [BW-1:0] frame_cnt;
    logic          blink_hidden;
    logic          refresh_done;
    logic          wrap;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic          unused_level;

    // Floor code is captured with the frame but no digit shows it yet.
    assign unused_level = ^level_sh;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign refresh_done = (refresh_cnt == REFRESH_LAST);
    assign wrap         = refresh_done && (scan_idx == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_s1 <= '0;
            status_s2 <= '0;
            level_s1  <= '0;
            level_s2  <= '0;
            clock_s1  <= '0;
            clock_s2  <= '0;
        end else begin
            status_s1 <= status_in;
            status_s2 <= status_s1;
            level_s1  <= level_in;
            level_s2  <= level_s1;
            clock_s1  <= clock_in;
            clock_s2  <= clock_s1;
        end
    end

    // Shadow and blink phase move only at the frame wrap so a frame is never torn.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_cnt  <= '0;
            scan_idx     <= 2'd0;
            frame_tick   <= 1'b0;
            frame_cnt    <= '0;
            blink_hidden <= 1'b0;
            status_sh    <= '0;
            level_sh     <= '0;
            clock_sh     <= '0;
        end else begin
            refresh_cnt <= refresh_done ? '0 : refresh_cnt + RW'(1);
            if (refresh_done) begin
                scan_idx <= scan_idx + 2'd1;
            end
            frame_tick <= wrap;
            if (wrap) begin
                status_sh <= status_s2;
                level_sh  <= level_s2;
                clock_sh  <= clock_s2;
                if (frame_cnt == BLINK_LAST) begin
                    frame_cnt    <= '0;
                    blink_hidden <= ~blink_hidden;
                end else begin
                    frame_cnt <= frame_cnt + BW'(1);
                end
            end
        end
    end

    always_comb begin
        an_nxt  = ~(4'b0001 << scan_idx);
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        case (scan_idx)
            2'd0: begin
                seg_nxt = hex_seg({2'b00, status_sh[4:3]} + 4'd1);
                dp_nxt  = ~status_sh[2];
            end
            2'd1: begin
                if (status_sh[7:5] == 3'd0) begin
                    seg_nxt = SEG_BLANK;
                end else if (status_sh[7:5] > 3'd4) begin
                    seg_nxt = SEG_E;
                end else begin
                    seg_nxt = hex_seg({1'b0, status_sh[7:5]});
                end
                // Blanking hides segments only; the digit stays enabled.
                if (status_sh[1] && blink_hidden) begin
                    seg_nxt = SEG_BLANK;
                end
            end
            2'd2: begin
                seg_nxt = status_sh[0] ? SEG_U : SEG_D;
            end
            default: begin
                seg_nxt = hex_seg(clock_sh);
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_status_display_scan.sv
// Bench for status_display_scan: stimulus pushes expected digit contents per frame,
// a negedge monitor pops one entry whenever a new digit is enabled.
module tb_status_display_scan;

    localparam int RC = 4;
    localparam int BF = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    logic       clk;
    logic       reset;
    logic [7:0] status_in;
    logic [1:0] level_in;
    logic [3:0] clock_in;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    disp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    m_cnt = 0;
    logic  m_hidden = 1'b0;

    status_display_scan #(.REFRESH_CNT(RC), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .reset      (reset),
        .status_in  (status_in),
        .level_in   (level_in),
        .clock_in   (clock_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic void model_tick();
        if (m_cnt == BF - 1) begin
            m_cnt    = 0;
            m_hidden = ~m_hidden;
        end else begin
            m_cnt++;
        end
    endfunction

    function automatic void push_frame(input logic [7:0] st, input logic [3:0] ck);
        disp_t d;
        logic [6:0] s1;
        d = '{an: 4'b1110, seg: enc({2'b00, st[4:3]} + 4'd1), dp: ~st[2]};
        exp_q.push_back(d);
        if (st[7:5] == 3'd0)      s1 = 7'h7F;
        else if (st[7:5] > 3'd4)  s1 = 7'h06;
        else                      s1 = enc({1'b0, st[7:5]});
        if (st[1] && m_hidden)    s1 = 7'h7F;
        d = '{an: 4'b1101, seg: s1, dp: 1'b1};
        exp_q.push_back(d);
        d = '{an: 4'b1011, seg: st[0] ? 7'h41 : 7'h21, dp: 1'b1};
        exp_q.push_back(d);
        d = '{an: 4'b0111, seg: enc(ck), dp: 1'b1};
        exp_q.push_back(d);
    endfunction

    task automatic drive(input logic [7:0] st, input logic [3:0] ck);
        status_in = st;
        level_in  = st[4:3];
        clock_in  = ck;
    endtask

    // Waits for the next frame_tick, optionally delays into the frame, then applies
    // inputs that the following wrap will capture.
    task automatic next_frame(input logic [7:0] st, input logic [3:0] ck, input int dly);
        int n = 0;
        @(negedge clk);
        while (!frame_tick && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("frame_tick_wait", {31'd0, frame_tick}, 32'd1);
        repeat (dly) @(negedge clk);
        drive(st, ck);
        model_tick();
        push_frame(st, ck);
    endtask

    // Monitor: reset values, one-hot enables, dwell length, tick spacing, digit contents.
    initial begin
        logic [3:0] prev_an;
        int dwell;
        int tick_gap;
        disp_t got;
        disp_t want;
        prev_an  = 4'hF;
        dwell    = 0;
        tick_gap = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("reset_outputs", {20'd0, an, seg, dp}, {20'd0, 4'hF, 7'h7F, 1'b1});
                check("reset_frame_tick", {31'd0, frame_tick}, 32'd0);
                prev_an  = 4'hF;
                dwell    = 0;
                tick_gap = 0;
            end else begin
                tick_gap++;
                check("an_onehot", $countones(~an), 32'd1);
                if (an != prev_an) begin
                    if (prev_an != 4'hF) check("dwell_len", dwell, RC);
                    dwell = 1;
                    got = '{an: an, seg: seg, dp: dp};
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_digit actual=%0h expected=none", got);
                    end else begin
                        want = exp_q.pop_front();
                        check("digit", {20'd0, got}, {20'd0, want});
                    end
                    prev_an = an;
                end else begin
                    dwell++;
                end
                if (frame_tick) begin
                    check("tick_gap", tick_gap, 4 * RC);
                    tick_gap = 0;
                end
            end
        end
    end

    initial begin
        int n;
        logic [7:0] st;
        reset = 1'b0;
        drive(8'h00, 4'h0);
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        push_frame(8'h00, 4'h0);
        drive(8'b011_10_1_0_1, 4'hA);
        model_tick();
        push_frame(8'b011_10_1_0_1, 4'hA);
        next_frame(8'b011_10_1_0_1, 4'hA, 0);
        for (int i = 0; i < 5; i++) next_frame(8'b110_00_0_1_1, 4'h3, 0);
        next_frame(8'b001_11_0_0_0, 4'h7, 5);
        next_frame(8'b001_11_0_0_0, 4'h7, 0);

        n = 0;
        while (an != 4'b1011 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_digit2", {28'd0, an}, {28'd0, 4'b1011});
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset", {20'd0, an, seg, dp}, {20'd0, 4'hF, 7'h7F, 1'b1});
        exp_q.delete();
        m_cnt    = 0;
        m_hidden = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        push_frame(8'h00, 4'h0);
        drive(8'b100_01_0_0_0, 4'hF);
        model_tick();
        push_frame(8'b100_01_0_0_0, 4'hF);
        for (int i = 0; i < 64; i++) begin
            case (i % 3)
                0:       st = 8'b100_01_0_0_0;
                1:       st = 8'b101_11_1_1_0;
                default: st = 8'b000_00_0_1_0;
            endcase
            next_frame(st, 4'hF, 0);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
